// File: rtl/fir_pkg.sv
// Shared defaults and feeder state encoding for the FIR sample feeder and the FIR stage.
package fir_pkg;

  localparam int FIR_WIDTH      = 24;
  localparam int FIR_TAPS       = 128;
  localparam int FIR_FIFO_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feed_state_e;

endpackage

// File: rtl/fir_feed_fifo.sv
// Single-clock sample FIFO; pointers carry one extra wrap bit so level is a plain difference.
module fir_feed_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered ADC samples to a FIR, holding each sample for TAPS step cycles.
// state | meaning
// IDLE  | no frame in progress, fir_ready low, fir_sig holds last sample
// RUN   | frame in progress, fir_ready high, cnt counts 0..TAPS-1
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH      = FIR_WIDTH,
  parameter int TAPS       = FIR_TAPS,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              fir_sig,
  output logic                          fir_ready,
  output logic                          res_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);

  localparam int            CW       = $clog2(TAPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);

  feed_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fir_sig_q, fir_sig_d;
  logic             fir_ready_q, fir_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             seen_q, seen_d;

  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;

  fir_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fir_sig_d = fir_sig_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          fir_sig_d = fifo_dout;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            fir_sig_d = fifo_dout;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    fir_ready_d = (state_d == RUN);
    // The FIR result register shows the previous frame's sum one cycle into each new frame.
    res_valid_d = (state_q == RUN) && (cnt_q == '0) && seen_q;
    seen_d      = seen_q | ((state_q == RUN) && (cnt_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fir_sig_q   <= '0;
      fir_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fir_sig_q   <= fir_sig_d;
      fir_ready_q <= fir_ready_d;
      res_valid_q <= res_valid_d;
      seen_q      <= seen_d;
    end
  end

  assign in_ready  = ~fifo_full;
  assign fir_sig   = fir_sig_q;
  assign fir_ready = fir_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q == RUN);

endmodule
